mult_arbiter: RTL

Shares one combinational `multiplier` instance (WIDTH-parameterised, ports i_var1/i_var2/o_mult) between N_REQ requesters. Each requester presents an operand pair with a request; the block arbitrates round-robin and registers the winner's operands into the shared multiplier. It registers the product and returns it with a per-requester valid pulse. It sits between the requester logic and the multiplier datapath.

---
 rtl/mult_arbiter.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/mult_arbiter.sv
// rtl/mult_arbiter.sv - round-robin arbiter time-sharing one combinational multiplier
//
// Purpose:
//   N_REQ requesters each present an operand pair and a request level. The
//   arbiter picks one winner per operation, registers the winner's operands
//   into a shared combinational multiplier, registers the product and returns
//   it with a one-hot valid pulse addressed to the owning requester. One
//   operation completes every three cycles (IDLE -> CALC -> RESP).
//
// Optional feature:
//   MULT_ARB_FIXED_PRIO_EN - when defined, the lowest requesting index always
//   wins and no round-robin pointer exists (requester 0 can starve others).
//   When undefined (default), the search starts at a rotating pointer.
//
// Ports (mult_arbiter):
//   i_clk    in   1            clock, rising edge
//   i_rst_n  in   1            asynchronous active-low reset
//   i_req    in   N_REQ        per-requester request level
//   i_var1   in   N_REQ*WIDTH  operand A, requester k at [k*WIDTH +: WIDTH]
//   i_var2   in   N_REQ*WIDTH  operand B, same packing
//   o_gnt    out  N_REQ        one-hot grant pulse, operands captured
//   o_valid  out  N_REQ        one-hot result-valid pulse for the owner
//   o_mult   out  2*WIDTH      registered product, held until next CALC
//   o_busy   out  1            high while an operation is in flight
//
// Ports (multiplier):
//   i_var1   in   WIDTH        operand A
//   i_var2   in   WIDTH        operand B
//   o_mult   out  2*WIDTH      full-width unsigned product

module multiplier #(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0]   i_var1,
  input  logic [WIDTH-1:0]   i_var2,
  output logic [2*WIDTH-1:0] o_mult
);

  // Both operands are widened first so the full 2*WIDTH product is kept.
  assign o_mult = (2*WIDTH)'(i_var1) * (2*WIDTH)'(i_var2);

endmodule

module mult_arbiter #(
  parameter int WIDTH = 6,
  parameter int N_REQ = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [N_REQ-1:0]       i_req,
  input  logic [N_REQ*WIDTH-1:0] i_var1,
  input  logic [N_REQ*WIDTH-1:0] i_var2,
  output logic [N_REQ-1:0]       o_gnt,
  output logic [N_REQ-1:0]       o_valid,
  output logic [2*WIDTH-1:0]     o_mult,
  output logic                   o_busy
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int PW    = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] valid_q, valid_d;
  logic [PW-1:0]    mult_q, mult_d;
  logic [WIDTH-1:0] var1_q, var1_d;
  logic [WIDTH-1:0] var2_q, var2_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] search_start;
  logic [IDX_W-1:0] winner;
  logic [WIDTH-1:0] sel_var1, sel_var2;
  logic [PW-1:0]    product;

`ifdef MULT_ARB_FIXED_PRIO_EN
  // Fixed priority: every search begins at requester 0.
  assign search_start = '0;
`else
  logic [IDX_W-1:0] rr_q, rr_d;
  assign search_start = rr_q;
`endif

  // First set request bit at or after ptr, wrapping modulo N_REQ. The loop
  // runs from the farthest offset down so the nearest one is assigned last.
  function automatic logic [IDX_W-1:0] pick_winner(
    input logic [N_REQ-1:0] req,
    input logic [IDX_W-1:0] ptr
  );
    logic [IDX_W-1:0] pick;
    int               idx;
    pick = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % N_REQ;
      if (req[idx[IDX_W-1:0]]) begin
        pick = idx[IDX_W-1:0];
      end
    end
    return pick;
  endfunction

  assign winner = pick_winner(i_req, search_start);

  // Operand mux for the current winner; only consumed when leaving IDLE.
  always_comb begin
    sel_var1 = '0;
    sel_var2 = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (winner == IDX_W'(k)) begin
        sel_var1 = i_var1[k*WIDTH +: WIDTH];
        sel_var2 = i_var2[k*WIDTH +: WIDTH];
      end
    end
  end

  multiplier #(
    .WIDTH(WIDTH)
  ) u_multiplier (
    .i_var1(var1_q),
    .i_var2(var2_q),
    .o_mult(product)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = '0;
    valid_d = '0;
    mult_d  = mult_q;
    var1_d  = var1_q;
    var2_d  = var2_q;
    owner_d = owner_q;
`ifndef MULT_ARB_FIXED_PRIO_EN
    rr_d    = rr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (|i_req) begin
          owner_d = winner;
          var1_d  = sel_var1;
          var2_d  = sel_var2;
          gnt_d   = N_REQ'(1) << winner;
`ifndef MULT_ARB_FIXED_PRIO_EN
          rr_d    = (winner == IDX_W'(N_REQ - 1)) ? '0 : winner + IDX_W'(1);
`endif
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        mult_d  = product;
        valid_d = N_REQ'(1) << owner_q;
        state_d = S_RESP;
      end
      S_RESP: begin
        // Requests are ignored here; any still-held request is re-arbitrated
        // on the first IDLE edge.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      valid_q <= '0;
      mult_q  <= '0;
      var1_q  <= '0;
      var2_q  <= '0;
      owner_q <= '0;
`ifndef MULT_ARB_FIXED_PRIO_EN
      rr_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      mult_q  <= mult_d;
      var1_q  <= var1_d;
      var2_q  <= var2_d;
      owner_q <= owner_d;
`ifndef MULT_ARB_FIXED_PRIO_EN
      rr_q    <= rr_d;
`endif
    end
  end

  assign o_gnt   = gnt_q;
  assign o_valid = valid_q;
  assign o_mult  = mult_q;
  assign o_busy  = (state_q != S_IDLE);

endmodule
